painterengine_gpu_tmds_serializer: RTL and testbench

Consumer end of the 5x pixel clock scheme: runs on the 5x pixel clock and serializes one 10-bit TMDS symbol per channel per pixel period. It outputs 2 bits per 5x cycle (DDR pairs) for the three data channels and the TMDS clock channel. An internal phase counter wraps every 5 cycles, the same divide-by-5 cadence as the pixel clock generator. Symbols enter through a single-entry valid/ready holding register. The block sits between the TMDS encoders and the ODDR output primitives.

---
 rtl/painterengine_gpu_tmds_pkg.sv | 37 +++
 rtl/painterengine_gpu_tmds_shift_channel.sv | 31 +++
 rtl/painterengine_gpu_tmds_serializer.sv | 113 +++++++++++
 tb/tb_painterengine_gpu_tmds_serializer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/painterengine_gpu_tmds_pkg.sv
// Shared constants for the TMDS serializer: phase wrap point, TMDS control
// tokens and the 10-bit clock-channel pattern.
package painterengine_gpu_tmds_pkg;

  typedef logic [9:0] tmds_symbol_t;

  localparam logic [2:0] PHASE_LAST = 3'd4;

  localparam tmds_symbol_t CTRL_TOKEN_00 = 10'b1101010100;
  localparam tmds_symbol_t CTRL_TOKEN_01 = 10'b0010101011;
  localparam tmds_symbol_t CTRL_TOKEN_10 = 10'b0101010100;
  localparam tmds_symbol_t CTRL_TOKEN_11 = 10'b1010101011;

  // Sent on every data channel when no symbol is waiting at load time.
  localparam tmds_symbol_t FILL_SYMBOL = CTRL_TOKEN_00;

  // Five ones then five zeros, transmitted LSB first.
  localparam tmds_symbol_t CLK_PATTERN = 10'b0000011111;

  // DDR pair of the clock channel for a given phase.
  function automatic logic [1:0] clk_pair(input logic [2:0] phase);
    logic [1:0] pair;
    // NOTE: give every output a default before the case so no path leaves it
    // unassigned; otherwise combinational logic turns into a latch.
    pair = CLK_PATTERN[1:0];
    case (phase)
      3'd0:    pair = CLK_PATTERN[1:0];
      3'd1:    pair = CLK_PATTERN[3:2];
      3'd2:    pair = CLK_PATTERN[5:4];
      3'd3:    pair = CLK_PATTERN[7:6];
      3'd4:    pair = CLK_PATTERN[9:8];
      default: pair = CLK_PATTERN[1:0];
    endcase
    return pair;
  endfunction

endpackage

// File: rtl/painterengine_gpu_tmds_shift_channel.sv
// One TMDS data lane: a 10-bit register that loads a symbol on the phase-4
// cycle and otherwise shifts right by two, presenting its low two bits as the
// DDR pair (bit 0 goes out first).
module painterengine_gpu_tmds_shift_channel
  import painterengine_gpu_tmds_pkg::*;
(
  input  logic         i_wire_5x_pixel_clock,
  input  logic         i_wire_resetn,
  input  logic         load,
  input  tmds_symbol_t symbol,
  output logic [1:0]   tmds
);

  tmds_symbol_t shift;

  // Load a fresh symbol once per pixel period, otherwise move two bits on.
  always_ff @(posedge i_wire_5x_pixel_clock or negedge i_wire_resetn) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!i_wire_resetn) begin
      shift <= FILL_SYMBOL;
    end else if (load) begin
      shift <= symbol;
    end else begin
      shift <= {2'b00, shift[9:2]};
    end
  end

  assign tmds = shift[1:0];

endmodule

// File: rtl/painterengine_gpu_tmds_serializer.sv
// TMDS serializer on the 5x pixel clock: a divide-by-5 phase counter, a
// single-entry valid/ready holding register and three shift lanes emitting
// DDR pairs, plus the combinational clock-channel pattern.
// Define PAINTERENGINE_GPU_TMDS_UNDERRUN_EN to enable the sticky underrun flag.
module painterengine_gpu_tmds_serializer
  import painterengine_gpu_tmds_pkg::*;
(
  input  logic       i_wire_5x_pixel_clock,
  input  logic       i_wire_resetn,
  input  logic       i_wire_symbol_valid,
  input  logic [9:0] i_wire_symbol_ch0,
  input  logic [9:0] i_wire_symbol_ch1,
  input  logic [9:0] i_wire_symbol_ch2,
  output logic       o_wire_symbol_ready,
  output logic [1:0] o_wire_tmds_ch0,
  output logic [1:0] o_wire_tmds_ch1,
  output logic [1:0] o_wire_tmds_ch2,
  output logic [1:0] o_wire_tmds_clk,
  output logic       o_wire_pixel_strobe,
  input  logic       i_wire_underrun_clear,
  output logic       o_wire_underrun
);

  logic [2:0]   reg_phase;
  logic         phase_last;
  logic         full;
  logic         accept;
  tmds_symbol_t hold [3];
  tmds_symbol_t symbol_in [3];
  tmds_symbol_t load_value [3];
  logic [1:0]   tmds [3];

  assign symbol_in[0] = i_wire_symbol_ch0;
  assign symbol_in[1] = i_wire_symbol_ch1;
  assign symbol_in[2] = i_wire_symbol_ch2;

  assign phase_last          = (reg_phase == PHASE_LAST);
  assign o_wire_symbol_ready = !full || phase_last;
  assign accept              = i_wire_symbol_valid && o_wire_symbol_ready;
  assign o_wire_pixel_strobe = phase_last;
  assign o_wire_tmds_clk     = clk_pair(reg_phase);

  // Phase counter: 0..4 then wrap, never visiting 5..7.
  always_ff @(posedge i_wire_5x_pixel_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      reg_phase <= '0;
    end else if (phase_last) begin
      reg_phase <= '0;
    end else begin
      reg_phase <= reg_phase + 3'd1;
    end
  end

  // Full flag: an accept always refills; an unload at phase 4 empties it.
  always_ff @(posedge i_wire_5x_pixel_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      full <= 1'b0;
    end else if (accept) begin
      full <= 1'b1;
    end else if (phase_last) begin
      full <= 1'b0;
    end
  end

  // Holding data captured on every accepted handshake.
  always_ff @(posedge i_wire_5x_pixel_clock) begin
    // NOTE: the holding data has no reset; it is only consumed while full is
    // set, and full is reset, so the storage stays plain flops.
    if (accept) begin
      hold <= symbol_in;
    end
  end

  // Lanes: waiting symbol at phase 4, or the fill token on underrun.
  for (genvar i = 0; i < 3; i++) begin : g_lane
    assign load_value[i] = full ? hold[i] : FILL_SYMBOL;

    painterengine_gpu_tmds_shift_channel u_lane (
      .i_wire_5x_pixel_clock (i_wire_5x_pixel_clock),
      .i_wire_resetn         (i_wire_resetn),
      .load                  (phase_last),
      .symbol                (load_value[i]),
      .tmds                  (tmds[i])
    );
  end

  assign o_wire_tmds_ch0 = tmds[0];
  assign o_wire_tmds_ch1 = tmds[1];
  assign o_wire_tmds_ch2 = tmds[2];

`ifdef PAINTERENGINE_GPU_TMDS_UNDERRUN_EN
  logic underrun;

  // Sticky underrun: set by a fill load, cleared on request; set wins.
  always_ff @(posedge i_wire_5x_pixel_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      underrun <= 1'b0;
    end else if (phase_last && !full) begin
      underrun <= 1'b1;
    end else if (i_wire_underrun_clear) begin
      underrun <= 1'b0;
    end
  end

  assign o_wire_underrun = underrun;
`else
  logic unused_underrun_clear;

  assign unused_underrun_clear = i_wire_underrun_clear;
  assign o_wire_underrun       = 1'b0;
`endif

endmodule

// File: tb/tb_painterengine_gpu_tmds_serializer.sv
// Self-checking bench for the TMDS serializer: directed phases with random
// symbols and handshakes, compared against a pixel-period level model.
module tb_painterengine_gpu_tmds_serializer;
  import painterengine_gpu_tmds_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid;
  logic [9:0] sym0, sym1, sym2;
  logic       clr;
  logic       ready;
  logic [1:0] tmds0, tmds1, tmds2, tmds_clk;
  logic       strobe;
  logic       underrun;

  painterengine_gpu_tmds_serializer dut (
    .i_wire_5x_pixel_clock (clk),
    .i_wire_resetn         (rst_n),
    .i_wire_symbol_valid   (valid),
    .i_wire_symbol_ch0     (sym0),
    .i_wire_symbol_ch1     (sym1),
    .i_wire_symbol_ch2     (sym2),
    .o_wire_symbol_ready   (ready),
    .o_wire_tmds_ch0       (tmds0),
    .o_wire_tmds_ch1       (tmds1),
    .o_wire_tmds_ch2       (tmds2),
    .o_wire_tmds_clk       (tmds_clk),
    .o_wire_pixel_strobe   (strobe),
    .i_wire_underrun_clear (clr),
    .o_wire_underrun       (underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pixel-period view (symbol on the wire, bit position,
  // one-deep waiting slot, sticky flag).
  int         m_phase;
  bit         m_full;
  logic [9:0] m_hold [3];
  logic [9:0] m_cur  [3];
  bit         m_under;
  bit         m_accepted;
  logic [1:0] clk_tab [5];

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pair on the wire at phase p is bits [2p+1:2p] of the symbol in flight.
  function automatic logic [9:0] pair_of(input logic [9:0] s, input int p);
    return (s >> (2 * p)) & 10'd3;
  endfunction

  task automatic model_reset();
    m_phase    = 0;
    m_full     = 1'b0;
    m_under    = 1'b0;
    m_accepted = 1'b0;
    for (int i = 0; i < 3; i++) m_cur[i] = FILL_SYMBOL;
  endtask

  task automatic check_outputs();
    check("ch0", tmds0, pair_of(m_cur[0], m_phase));
    check("ch1", tmds1, pair_of(m_cur[1], m_phase));
    check("ch2", tmds2, pair_of(m_cur[2], m_phase));
    check("clk", tmds_clk, clk_tab[m_phase]);
    check("ready", ready, (!m_full || m_phase == 4) ? 10'd1 : 10'd0);
    check("strobe", strobe, (m_phase == 4) ? 10'd1 : 10'd0);
`ifdef PAINTERENGINE_GPU_TMDS_UNDERRUN_EN
    check("underrun", underrun, m_under ? 10'd1 : 10'd0);
`else
    check("underrun", underrun, 10'd0);
`endif
  endtask

  // One 5x clock cycle: check at the falling edge, drive, then advance model.
  task automatic cycle(input bit v, input logic [9:0] a, input logic [9:0] b,
                       input logic [9:0] c, input bit cl);
    bit acc;
    bit fill;
    check_outputs();
    valid = v; sym0 = a; sym1 = b; sym2 = c; clr = cl;
    @(posedge clk);
    acc  = v && (!m_full || m_phase == 4);
    fill = (m_phase == 4) && !m_full;
    if (m_phase == 4) begin
      for (int i = 0; i < 3; i++) m_cur[i] = m_full ? m_hold[i] : FILL_SYMBOL;
      m_full = 1'b0;
    end
    if (acc) begin
      m_full = 1'b1;
      m_hold[0] = a; m_hold[1] = b; m_hold[2] = c;
    end
    if (fill) m_under = 1'b1;
    else if (cl) m_under = 1'b0;
    m_accepted = acc;
    m_phase = (m_phase + 1) % 5;
    @(negedge clk);
  endtask

  task automatic random_cycle(input int valid_pct, input int clr_pct);
    cycle(($urandom % 100) < valid_pct, 10'($urandom), 10'($urandom),
          10'($urandom), ($urandom % 100) < clr_pct);
  endtask

  initial begin
    bit alt;
    clk_tab[0] = 2'b11; clk_tab[1] = 2'b11; clk_tab[2] = 2'b01;
    clk_tab[3] = 2'b00; clk_tab[4] = 2'b00;
    rst_n = 1'b0; valid = 1'b0; clr = 1'b0;
    sym0 = '0; sym1 = '0; sym2 = '0;
    model_reset();

    // Reset values while held in reset.
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Idle: fill tokens, clock pattern, underrun after first load.
    repeat (15) cycle(1'b0, '0, '0, '0, 1'b0);
    // Clear pulsed every cycle: fill loads still win.
    repeat (10) cycle(1'b0, '0, '0, '0, 1'b1);
    repeat (3) cycle(1'b0, '0, '0, '0, 1'b0);

    // Sustained valid with alternating all-ones / all-zeros symbols.
    alt = 1'b0;
    for (int n = 0; n < 60; n++) begin
      cycle(1'b1, alt ? 10'h000 : 10'h3FF, 10'h2AA, 10'h155, n == 20);
      if (m_accepted) alt = ~alt;
    end

    // Full holding of 2AA, then 155 offered: both go out back to back.
    while (m_phase != 1) cycle(1'b0, '0, '0, '0, 1'b0);
    cycle(1'b1, 10'h2AA, 10'h2AA, 10'h2AA, 1'b0);
    cycle(1'b0, '0, '0, '0, 1'b0);
    cycle(1'b1, 10'h155, 10'h155, 10'h155, 1'b0);
    cycle(1'b1, 10'h155, 10'h155, 10'h155, 1'b0);
    cycle(1'b1, 10'h155, 10'h155, 10'h155, 1'b0);
    repeat (12) cycle(1'b0, '0, '0, '0, 1'b0);

    // Random handshakes, symbols and clears.
    repeat (300) random_cycle(70, 12);
    repeat (100) random_cycle(95, 5);

    // Asynchronous reset mid-symbol at phase 2.
    for (int n = 0; n < 5 && m_phase != 2; n++) random_cycle(90, 0);
    check("pre_reset_phase", 10'(m_phase), 10'd2);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Counting restarts from phase 0 after release.
    repeat (150) random_cycle(80, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
